// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, widths and default rates
// for the stopwatch mode controller and its button conditioner.
package stopwatch_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_RUN     = 2'd0;
  localparam logic [STATE_W-1:0] ST_PAUSED  = 2'd1;
  localparam logic [STATE_W-1:0] ST_ADJ     = 2'd2;
  localparam logic [STATE_W-1:0] ST_ILLEGAL = 2'd3;

  localparam int CLK_HZ_DEF   = 100_000_000;
  localparam int DEBOUNCE_DEF = 1_000_000;
  localparam int ADJ_DIV_DEF  = 2;

  // bits needed to hold a counter running 0..n-1
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce: 2-flop sync, optional debounce, rising-edge pulse.
// Ports: clk, rst (async, active-low), din (raw), pulse (1 cycle).
// Macro STOPWATCH_DEBOUNCE_EN enables the debounce counter.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;
  logic level;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  // any sample equal to the accepted level restarts the count
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = level;
    pulse_d = level & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mode FSM, tick prescaler and blink for MM:SS.
// In: clk, rst (async, active-low), btn_pause, btn_clr, sw_adj,
// sw_sel. Out: cnt_tick, cnt_clr, cnt_pause, adj_en, adj_sel,
// blink_en, state. Macro STOPWATCH_DEBOUNCE_EN adds debouncing.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = CLK_HZ_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int ADJ_DIV         = ADJ_DIV_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_pause,
  input  logic               btn_clr,
  input  logic               sw_adj,
  input  logic               sw_sel,
  output logic               cnt_tick,
  output logic               cnt_clr,
  output logic               cnt_pause,
  output logic               adj_en,
  output logic               adj_sel,
  output logic               blink_en,
  output logic [STATE_W-1:0] state
);

  localparam int ADJ_HZ =
    (CLK_HZ / ADJ_DIV > 0) ? CLK_HZ / ADJ_DIV : 1;
  localparam int BLINK_HZ =
    (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int PW = cnt_w(CLK_HZ);
  localparam int BW = cnt_w(BLINK_HZ);

  localparam logic [PW-1:0] RUN_LAST   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] ADJ_LAST   = PW'(ADJ_HZ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HZ - 1);

  logic pause_p, clr_p;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_pause (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_pause),
    .pulse(pause_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_clr),
    .pulse(clr_p)
  );

  logic adj_meta_q, adj_meta_d;
  logic adj_sync_q, adj_sync_d;
  logic sel_meta_q, sel_meta_d;
  logic sel_sync_q, sel_sync_d;

  logic [STATE_W-1:0] state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic               blink_q, blink_d;
  logic               tick_q, tick_d;
  logic               clr_q, clr_d;
  logic               pause_q, pause_d;
  logic               adj_q, adj_d;

  logic          changed;
  logic          counting;
  logic          term;
  logic [PW-1:0] last;

  always_comb begin
    adj_meta_d = sw_adj;
    adj_sync_d = adj_meta_q;
    sel_meta_d = sw_sel;
    sel_sync_d = sel_meta_q;
  end

  // adjust switch outranks the pause button
  always_comb begin
    state_d = state_q;
    if (state_q == ST_ILLEGAL) begin
      state_d = ST_PAUSED;
    end else if (adj_sync_q) begin
      state_d = ST_ADJ;
    end else begin
      unique case (1'b1)
        (state_q == ST_ADJ):    state_d = ST_PAUSED;
        (state_q == ST_RUN):    if (pause_p) state_d = ST_PAUSED;
        (state_q == ST_PAUSED): if (pause_p) state_d = ST_RUN;
        default:                state_d = ST_PAUSED;
      endcase
    end
  end

  // a tick is dropped when it collides with clear or a mode change
  always_comb begin
    changed  = (state_d != state_q);
    counting = (state_q == ST_RUN) || (state_q == ST_ADJ);
    last     = (state_q == ST_ADJ) ? ADJ_LAST : RUN_LAST;
    term     = counting && (presc_q == last);
    presc_d  = presc_q + 1'b1;
    if (!counting || changed || clr_p || term) begin
      presc_d = '0;
    end
    tick_d  = term && !clr_p && !changed;
    clr_d   = clr_p;
    pause_d = (state_d == ST_PAUSED);
    adj_d   = (state_d == ST_ADJ);
  end

  // blink restarts dark on every ADJ entry and is dark outside ADJ
  always_comb begin
    bcnt_d  = '0;
    blink_d = 1'b0;
    if ((state_q == ST_ADJ) && (state_d == ST_ADJ)) begin
      if (bcnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
        blink_d = blink_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adj_meta_q <= 1'b0;
      adj_sync_q <= 1'b0;
      sel_meta_q <= 1'b0;
      sel_sync_q <= 1'b0;
      state_q    <= ST_PAUSED;
      presc_q    <= '0;
      bcnt_q     <= '0;
      blink_q    <= 1'b0;
      tick_q     <= 1'b0;
      clr_q      <= 1'b0;
      pause_q    <= 1'b1;
      adj_q      <= 1'b0;
    end else begin
      adj_meta_q <= adj_meta_d;
      adj_sync_q <= adj_sync_d;
      sel_meta_q <= sel_meta_d;
      sel_sync_q <= sel_sync_d;
      state_q    <= state_d;
      presc_q    <= presc_d;
      bcnt_q     <= bcnt_d;
      blink_q    <= blink_d;
      tick_q     <= tick_d;
      clr_q      <= clr_d;
      pause_q    <= pause_d;
      adj_q      <= adj_d;
    end
  end

  assign cnt_tick  = tick_q;
  assign cnt_clr   = clr_q;
  assign cnt_pause = pause_q;
  assign adj_en    = adj_q;
  assign adj_sel   = sel_sync_q;
  assign blink_en  = blink_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed table plus hand sequences for
// stopwatch_ctrl with CLK_HZ=8, ADJ_DIV=2, DEBOUNCE_CYCLES=4.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT   = 8;
  localparam int CLR_D = 0;
`else
  localparam int LAT   = 4;
  localparam int CLR_D = 4;
`endif

  logic       clk;
  logic       rst;
  logic       btn_pause, btn_clr, sw_adj, sw_sel;
  logic       cnt_tick, cnt_clr, cnt_pause;
  logic       adj_en, adj_sel, blink_en;
  logic [1:0] state;

  stopwatch_ctrl #(
    .CLK_HZ         (8),
    .DEBOUNCE_CYCLES(4),
    .ADJ_DIV        (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_pause(btn_pause),
    .btn_clr  (btn_clr),
    .sw_adj   (sw_adj),
    .sw_sel   (sw_sel),
    .cnt_tick (cnt_tick),
    .cnt_clr  (cnt_clr),
    .cnt_pause(cnt_pause),
    .adj_en   (adj_en),
    .adj_sel  (adj_sel),
    .blink_en (blink_en),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int sc_cnt = 0;
  int tick_cnt = 0;
  int clr_cnt = 0;
  logic [1:0] prev_st = 2'd1;

  always @(negedge clk) begin
    if (state !== prev_st) sc_cnt++;
    prev_st = state;
    if (cnt_tick === 1'b1) tick_cnt++;
    if (cnt_clr === 1'b1) clr_cnt++;
  end

  task automatic chk(input string name, input int act,
                     input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s,
                            input int bound, output int n);
    n = 0;
    while (state !== s && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic wait_tick(input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (cnt_tick !== 1'b1 && n < bound);
  endtask

  task automatic press_pause(input int hold);
    btn_pause = 1'b1;
    fork
      begin
        repeat (hold) step();
        btn_pause = 1'b0;
      end
    join_none
  endtask

  typedef struct {
    logic       pb, cb, adj, sel;
    int         cyc;
    logic [1:0] st;
    logic       pz, ae, asel;
    int         nclr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, s0, t0, c0;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1,  4, 2'd2, 1'b0, 1'b1, 1'b1, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0,  3, 2'd2, 1'b0, 1'b1, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 12, 2'd2, 1'b0, 1'b1, 1'b0, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 12, 2'd2, 1'b0, 1'b1, 1'b1, 0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0,  4, 2'd1, 1'b1, 1'b0, 1'b0, 0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 12, 2'd1, 1'b1, 1'b0, 1'b0, 1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0,  8, 2'd1, 1'b1, 1'b0, 1'b0, 0};

    // reset values and idle
    rst = 1'b0;
    btn_pause = 1'b0;
    btn_clr = 1'b0;
    sw_adj = 1'b0;
    sw_sel = 1'b0;
    #12;
    chk("rst_state", state, 1);
    chk("rst_cnt_pause", cnt_pause, 1);
    chk("rst_cnt_tick", cnt_tick, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_adj_en", adj_en, 0);
    chk("rst_blink", blink_en, 0);
    step();
    rst = 1'b1;
    t0 = tick_cnt;
    repeat (20) step();
    chk("idle_ticks", tick_cnt - t0, 0);
    chk("idle_state", state, 1);
    chk("idle_cnt_pause", cnt_pause, 1);

    // held press: one transition, ticks every 8
    s0 = sc_cnt;
    press_pause(10);
    wait_state(2'd0, 30, n);
    chk("run_reach", state, 0);
    chk("run_latency", n, LAT);
    chk("run_cnt_pause", cnt_pause, 0);
    wait_tick(20, n);
    chk("tick1_seen", cnt_tick, 1);
    chk("tick1_delay", n, 8);
    wait_tick(20, n);
    chk("tick2_delay", n, 8);
    step();
    chk("tick_width", cnt_tick, 0);
    chk("hold_one_transition", sc_cnt - s0, 1);
    chk("hold_still_run", state, 0);

    press_pause(6);
    wait_state(2'd1, 30, n);
    chk("pause_reach", state, 1);
    chk("pause_latency", n, LAT);
    t0 = tick_cnt;
    repeat (20) step();
    chk("paused_no_ticks", tick_cnt - t0, 0);
    chk("paused_cnt_pause", cnt_pause, 1);

`ifdef STOPWATCH_DEBOUNCE_EN
    // bounce shorter than the debounce window
    s0 = sc_cnt;
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
    step();
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
    repeat (15) step();
    chk("bounce_state", state, 1);
    chk("bounce_transitions", sc_cnt - s0, 0);
`endif

    // adjust/clear level table from PAUSED
    for (int i = 0; i < 7; i++) begin
      btn_pause = tbl[i].pb;
      btn_clr   = tbl[i].cb;
      sw_adj    = tbl[i].adj;
      sw_sel    = tbl[i].sel;
      c0 = clr_cnt;
      repeat (tbl[i].cyc) step();
      chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d_pause", i), cnt_pause, tbl[i].pz);
      chk($sformatf("tbl%0d_adj_en", i), adj_en, tbl[i].ae);
      chk($sformatf("tbl%0d_adj_sel", i), adj_sel, tbl[i].asel);
      chk($sformatf("tbl%0d_clr", i), clr_cnt - c0, tbl[i].nclr);
      if (tbl[i].st != 2'd2)
        chk($sformatf("tbl%0d_blink", i), blink_en, 0);
    end

    // RUN -> ADJ: tick every 4, blink every 2
    press_pause(6);
    wait_state(2'd0, 30, n);
    chk("run2_reach", state, 0);
    sw_sel = 1'b1;
    sw_adj = 1'b1;
    wait_state(2'd2, 10, n);
    chk("adj_reach", state, 2);
    chk("adj_en", adj_en, 1);
    chk("adj_sel", adj_sel, 1);
    chk("adj_cnt_pause", cnt_pause, 0);
    chk("adj_blink0", blink_en, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("adj_blink_k%0d", k), blink_en, (k / 2) % 2);
      chk($sformatf("adj_tick_k%0d", k), cnt_tick,
          (k % 4 == 0) ? 1 : 0);
    end
    sw_adj = 1'b0;
    wait_state(2'd1, 10, n);
    chk("adj_exit_state", state, 1);
    chk("adj_exit_blink", blink_en, 0);
    chk("adj_exit_adj_en", adj_en, 0);
    chk("adj_exit_cnt_pause", cnt_pause, 1);

    // clear landing on the terminal count
    press_pause(6);
    wait_state(2'd0, 30, n);
    chk("run3_reach", state, 0);
    wait_tick(20, n);
    chk("run3_tick_delay", n, 8);
    repeat (CLR_D) step();
    btn_clr = 1'b1;
    fork
      begin
        repeat (6) step();
        btn_clr = 1'b0;
      end
    join_none
    for (int k = 1; k <= 9 - CLR_D; k++) begin
      step();
      chk($sformatf("coll_clr_k%0d", k), cnt_clr,
          (k == 8 - CLR_D) ? 1 : 0);
      chk($sformatf("coll_tick_k%0d", k), cnt_tick, 0);
    end
    wait_tick(20, n);
    chk("coll_next_tick", n, 7);
    chk("coll_state", state, 0);

    // asynchronous reset between edges
    chk("pre_reset_state", state, 0);
    chk("pre_reset_adj_sel", adj_sel, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_state", state, 1);
    chk("async_cnt_pause", cnt_pause, 1);
    chk("async_cnt_tick", cnt_tick, 0);
    chk("async_cnt_clr", cnt_clr, 0);
    chk("async_adj_en", adj_en, 0);
    chk("async_adj_sel", adj_sel, 0);
    chk("async_blink", blink_en, 0);
    step();
    rst = 1'b1;
    step();
    chk("post_reset_state", state, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Mode controller and timebase for the 4-digit MM:SS stopwatch counter. It turns raw board buttons and switches into clean control strobes: count enable ticks, clear, pause, adjust mode, and adjust-digit select. It also generates a blink enable for the display driver. It sits between the board I/O and the counter/display datapath, and it is the only block that decides when the counter advances.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; 1 Hz run tick period in cycles.
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before a button level is accepted.
ADJ_DIV, 2, adjust-mode tick rate multiplier; adjust tick period is CLK_HZ/ADJ_DIV cycles.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
btn_pause  in  1  raw pause/run button, active-high, asynchronous to clk.
btn_clr  in  1  raw clear button, active-high, asynchronous to clk.
sw_adj  in  1  adjust-mode switch level, asynchronous.
sw_sel  in  1  adjust select level: 0 = seconds, 1 = minutes; asynchronous.
cnt_tick  out  1  one-cycle count enable to the counter.
cnt_clr  out  1  one-cycle clear strobe to the counter.
cnt_pause  out  1  level; high in PAUSED state.
adj_en  out  1  level; high in ADJ state.
adj_sel  out  1  synchronized sw_sel; valid while adj_en=1.
blink_en  out  1  toggles every CLK_HZ/4 cycles in ADJ; 0 otherwise.
state  out  2  current FSM state, for debug LEDs.

Behaviour:
- Reset (rst=0, asynchronous): state=PAUSED, and every output is 0 except cnt_pause=1. Prescaler=0. Synchronizers and debouncers are cleared.
- Input conditioning: every input passes through a 2-flop synchronizer. The switches are used as levels directly after synchronization. The buttons are debounced and then rising-edge detected, giving one-cycle press pulses (pause_p, clr_p).
- Debounce: the accepted button level changes only after the synchronized input has held the new value for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count. Holding a button produces exactly one pulse; auto-repeat is not allowed.
- FSM states: RUN=0, PAUSED=1, ADJ=2. Value 3 is illegal and recovers to PAUSED on the next cycle.
  - RUN: pause_p goes to PAUSED.
  - PAUSED: pause_p goes to RUN.
  - Any state with sw_adj=1 goes to ADJ. sw_adj has priority over pause_p in the same cycle.
  - ADJ with sw_adj=0 goes to PAUSED. pause_p is ignored in ADJ.
- Prescaler: a free counter 0..DIV-1. DIV is CLK_HZ in RUN and CLK_HZ/ADJ_DIV in ADJ.
  - cnt_tick=1 for exactly the one cycle where the count equals DIV-1; the count then wraps to 0.
  - In PAUSED the count is held at 0 and cnt_tick=0.
  - The count is forced to 0 on every state change and on clr_p. The first tick after entering RUN therefore lands exactly CLK_HZ cycles later.
- Clear: clr_p produces cnt_clr=1 for one cycle, registered, the cycle after clr_p. Clear is accepted in every state and does not change the state.
- Clear/tick collision: if clr_p and a terminal prescaler count coincide, cnt_clr=1, cnt_tick=0, and the prescaler restarts at 0.
- Output timing: all outputs are registered and glitch-free.
- Adjust interaction: the counter saturates at 59:59 itself; this controller does not track counter value.

Optional Feature:
Macro STOPWATCH_DEBOUNCE_EN.
- Defined: buttons pass through the debouncer as described above.
- Undefined: the debouncer is removed and buttons are treated as clean. The edge detector follows the synchronizer directly, so a press pulse appears 3 cycles after the raw rising edge. DEBOUNCE_CYCLES is unused.

Decomposition:
- Package stopwatch_pkg holds:
  - the state encoding (RUN, PAUSED, ADJ, plus the illegal value),
  - the 2-bit state width constant,
  - the default CLK_HZ and DEBOUNCE_CYCLES constants, shared with the top level.
- One sub-module, btn_debounce: synchronizer, debounce counter and rising-edge pulse. It is instantiated twice, for pause and clear; its debounce stage is compiled under the macro.

Test Plan (CLK_HZ=8, ADJ_DIV=2, DEBOUNCE_CYCLES=4, macro defined):
- Reset then idle 20 cycles -> state=1, cnt_pause=1, cnt_tick never asserted.
- Hold btn_pause for 10 cycles -> exactly one transition to RUN. cnt_tick pulses every 8 cycles, the first exactly 8 cycles after the state change. A second press returns to PAUSED with no further ticks.
- Toggle btn_pause every cycle for 3 cycles, then release -> no state change and no pulse.
- In RUN set sw_adj=1 and sw_sel=1 -> state=2, adj_en=1, adj_sel=1. cnt_tick every 4 cycles; blink_en toggles every 2 cycles. Clearing sw_adj returns state=1 and drops blink_en to 0.
- Press btn_clr in RUN so that clr_p coincides with the prescaler terminal count -> single-cycle cnt_clr, no cnt_tick that cycle, next tick 8 cycles later, state stays RUN.
- Assert rst=0 mid-RUN, between clock edges -> outputs drop to their reset values immediately, without waiting for a clock edge. After release, state=PAUSED.
